// File: rtl/elevator_pkg.sv
// Shared types and default constants for the elevator motion controller.
// Optional door-hold input is enabled by defining DOOR_HOLD_EN.
package elevator_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMove,
    StDoor
  } state_e;

  localparam int unsigned DefFloors     = 8;
  localparam int unsigned DefFloorW     = 3;
  localparam int unsigned DefStepCycles = 4;
  localparam int unsigned DefDoorCycles = 8;

  // Asserted level of up, down and call_n.
  localparam logic ActiveLow = 1'b0;

endpackage

// File: rtl/call_scheduler.sv
// SCAN helper: classifies latched calls relative to the cabin floor and the
// current travel direction.
module call_scheduler #(
  parameter int unsigned FLOORS  = 8,
  parameter int unsigned FLOOR_W = 3
) (
  input  logic [FLOORS-1:0]  pending_i,
  input  logic [FLOOR_W-1:0] cur_floor_i,
  input  logic               dir_up_i,
  output logic               here_o,
  output logic               ahead_o,
  output logic               behind_o
);

  logic above;
  logic below;

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      if (pending_i[i]) begin
        if (i > 32'(cur_floor_i)) begin
          above = 1'b1;
        end else if (i < 32'(cur_floor_i)) begin
          below = 1'b1;
        end
      end
    end
  end

  assign here_o   = pending_i[cur_floor_i];
  assign ahead_o  = dir_up_i ? above : below;
  assign behind_o = dir_up_i ? below : above;

endmodule

// File: rtl/elevator_motion_ctrl.sv
// SCAN elevator controller driving an external up/down floor counter.
// Define DOOR_HOLD_EN to add the door_hold_n input that holds the door open.
module elevator_motion_ctrl
  import elevator_pkg::*;
#(
  parameter int unsigned FLOORS      = DefFloors,
  parameter int unsigned FLOOR_W     = DefFloorW,
  parameter int unsigned STEP_CYCLES = DefStepCycles,
  parameter int unsigned DOOR_CYCLES = DefDoorCycles
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOORS-1:0]  call_n,
  input  logic               P,
`ifdef DOOR_HOLD_EN
  input  logic               door_hold_n,
`endif
  output logic               up,
  output logic               down,
  output logic [FLOOR_W-1:0] cur_floor,
  output logic               dir_up,
  output logic               moving,
  output logic               door_open,
  output logic [FLOORS-1:0]  pending
);

  localparam int unsigned StepW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned DoorW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [StepW-1:0]   StepLast = StepW'(STEP_CYCLES - 1);
  localparam logic [DoorW-1:0]   DoorLast = DoorW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TopFloor = FLOOR_W'(FLOORS - 1);

  state_e             state_q, state_d;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic               dir_q, dir_d;
  logic [FLOORS-1:0]  pending_q, pending_d;
  logic [StepW-1:0]   step_q, step_d;
  logic [DoorW-1:0]   door_q, door_d;
  logic               up_q, up_d;
  logic               down_q, down_d;

  logic [FLOORS-1:0]  calls_in;
  logic               door_hold;
  logic               step_term;
  logic               step_ok;
  logic [FLOOR_W-1:0] floor_step;
  logic [FLOOR_W-1:0] sched_floor;
  logic               here;
  logic               ahead;
  logic               behind;

  always_comb begin
    calls_in = '0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      calls_in[i] = (call_n[i] == ActiveLow);
    end
  end

`ifdef DOOR_HOLD_EN
  assign door_hold = (door_hold_n == ActiveLow);
`else
  assign door_hold = 1'b0;
`endif

  assign step_term  = (step_q == StepLast);
  assign step_ok    = dir_q ? (floor_q != TopFloor) : (floor_q != '0);
  assign floor_step = dir_q ? (floor_q + 1'b1) : (floor_q - 1'b1);
  // Post-step SCAN decisions look at the floor the cabin is arriving at.
  assign sched_floor = (state_q == StMove && step_term && step_ok) ? floor_step : floor_q;

  call_scheduler #(
    .FLOORS  (FLOORS),
    .FLOOR_W (FLOOR_W)
  ) u_call_scheduler (
    .pending_i   (pending_q),
    .cur_floor_i (sched_floor),
    .dir_up_i    (dir_q),
    .here_o      (here),
    .ahead_o     (ahead),
    .behind_o    (behind)
  );

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_d     = dir_q;
    step_d    = step_q;
    door_d    = door_q;
    up_d      = ~ActiveLow;
    down_d    = ~ActiveLow;
    pending_d = pending_q | calls_in;

    if (!P) begin
      unique case (state_q)
        StIdle: begin
          if (here) begin
            state_d = StDoor;
            door_d  = '0;
          end else if (ahead) begin
            state_d = StMove;
            step_d  = '0;
          end else if (behind) begin
            state_d = StMove;
            step_d  = '0;
            dir_d   = ~dir_q;
          end
        end
        StMove: begin
          if (step_term) begin
            step_d = '0;
            if (step_ok) begin
              floor_d = floor_step;
              if (dir_q) begin
                up_d = ActiveLow;
              end else begin
                down_d = ActiveLow;
              end
            end
            if (here) begin
              state_d = StDoor;
              door_d  = '0;
            end else if (!ahead) begin
              if (behind) begin
                dir_d = ~dir_q;
              end else begin
                state_d = StIdle;
              end
            end
          end else begin
            step_d = step_q + 1'b1;
          end
        end
        StDoor: begin
          // A fresh call at this floor keeps the door open a full period.
          if (door_hold || calls_in[floor_q]) begin
            door_d = '0;
          end else if (door_q == DoorLast) begin
            state_d = StIdle;
          end else begin
            door_d = door_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (state_d == StDoor) begin
      pending_d[floor_d] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      floor_q   <= '0;
      dir_q     <= 1'b1;
      pending_q <= '0;
      step_q    <= '0;
      door_q    <= '0;
      up_q      <= ~ActiveLow;
      down_q    <= ~ActiveLow;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
      step_q    <= step_d;
      door_q    <= door_d;
      up_q      <= up_d;
      down_q    <= down_d;
    end
  end

  assign up        = up_q;
  assign down      = down_q;
  assign cur_floor = floor_q;
  assign dir_up    = dir_q;
  assign moving    = (state_q == StMove);
  assign door_open = (state_q == StDoor);
  assign pending   = pending_q;

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Directed bench for elevator_motion_ctrl with default parameters
// (8 floors, 4-cycle steps, 8-cycle door).
module tb_elevator_motion_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] call_n;
  logic       P;
  logic       up;
  logic       down;
  logic [2:0] cur_floor;
  logic       dir_up;
  logic       moving;
  logic       door_open;
  logic [7:0] pending;

  int checks = 0;
  int errors = 0;
  int wrong_pulses = 0;
  int t;
  int n;
  int ups;
  int downs;

  elevator_motion_ctrl #(
    .FLOORS      (8),
    .FLOOR_W     (3),
    .STEP_CYCLES (4),
    .DOOR_CYCLES (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .call_n      (call_n),
    .P           (P),
`ifdef DOOR_HOLD_EN
    .door_hold_n (1'b1),
`endif
    .up          (up),
    .down        (down),
    .cur_floor   (cur_floor),
    .dir_up      (dir_up),
    .moving      (moving),
    .door_open   (door_open),
    .pending     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      checks++;
      assert ({up, down} !== 2'b00) else begin
        errors++;
        $error("FAIL up_down_exclusive: observed up=%b down=%b, required not both 0", up, down);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [7:0] mask);
    call_n = ~mask;
    tick();
    call_n = 8'hFF;
  endtask

  task automatic wait_pulse(input bit want_up, input int max_ticks, output int ticks);
    bit found;
    found = 1'b0;
    ticks = 0;
    while (!found && ticks < max_ticks) begin
      tick();
      ticks++;
      if (want_up ? (up === 1'b0) : (down === 1'b0)) found = 1'b1;
      else if (up === 1'b0 || down === 1'b0) wrong_pulses++;
    end
    check(want_up ? "up_pulse_seen" : "down_pulse_seen", {31'd0, found}, 32'd1);
  endtask

  // Counts samples with the door open, starting with the current one.
  task automatic door_time(output int cnt);
    cnt = (door_open === 1'b1) ? 1 : 0;
    for (int i = 0; i < 40 && door_open === 1'b1; i++) begin
      tick();
      if (door_open === 1'b1) cnt++;
    end
  endtask

  task automatic run_cycles(input int cyc, output int nu, output int nd);
    nu = 0;
    nd = 0;
    for (int i = 0; i < cyc; i++) begin
      tick();
      if (up === 1'b0) nu++;
      if (down === 1'b0) nd++;
    end
  endtask

  initial begin
    reset  = 1'b0;
    call_n = 8'hFF;
    P      = 1'b0;
    tick();
    tick();
    check("rst_up", {31'd0, up}, 32'd1);
    check("rst_down", {31'd0, down}, 32'd1);
    check("rst_floor", {29'd0, cur_floor}, 32'd0);
    check("rst_dir", {31'd0, dir_up}, 32'd1);
    check("rst_state", {30'd0, moving, door_open}, 32'd0);
    check("rst_pending", {24'd0, pending}, 32'd0);
    reset = 1'b1;
    tick();

    // Single call to floor 3: latch + decision + 4 step cycles to first pulse.
    press(8'h08);
    check("t1_latched", {24'd0, pending}, 32'h08);
    wait_pulse(1'b1, 20, t);
    check("t1_latency", 32'(t + 1), 32'd6);
    wait_pulse(1'b1, 20, t);
    check("t1_spacing2", 32'(t), 32'd4);
    wait_pulse(1'b1, 20, t);
    check("t1_spacing3", 32'(t), 32'd4);
    check("t1_floor", {29'd0, cur_floor}, 32'd3);
    check("t1_door", {31'd0, door_open}, 32'd1);
    check("t1_pending", {24'd0, pending}, 32'd0);
    door_time(n);
    check("t1_door_len", 32'(n), 32'd8);
    check("t1_idle", {30'd0, moving, door_open}, 32'd0);
    run_cycles(5, ups, downs);
    check("t1_no_extra", 32'(ups + downs), 32'd0);

    // Calls at 1 and 6 from floor 3 heading up: serve 6, then reverse to 1.
    press(8'h42);
    for (int i = 0; i < 3; i++) wait_pulse(1'b1, 20, t);
    check("t2_floor6", {29'd0, cur_floor}, 32'd6);
    check("t2_door6", {31'd0, door_open}, 32'd1);
    check("t2_dir6", {31'd0, dir_up}, 32'd1);
    check("t2_pend6", {24'd0, pending}, 32'h02);
    door_time(n);
    for (int i = 0; i < 5; i++) wait_pulse(1'b0, 20, t);
    check("t2_floor1", {29'd0, cur_floor}, 32'd1);
    check("t2_door1", {31'd0, door_open}, 32'd1);
    check("t2_dir1", {31'd0, dir_up}, 32'd0);
    check("t2_pend1", {24'd0, pending}, 32'd0);
    check("t2_wrong_pulses", 32'(wrong_pulses), 32'd0);
    door_time(n);

    // Re-call of the current floor at door cycle 5 restarts the door timer.
    press(8'h04);
    wait_pulse(1'b1, 20, t);
    check("t3_floor2", {29'd0, cur_floor}, 32'd2);
    check("t3_door", {31'd0, door_open}, 32'd1);
    for (int i = 0; i < 5; i++) tick();
    press(8'h04);
    check("t3_pend_clear", {24'd0, pending}, 32'd0);
    door_time(n);
    check("t3_door_restart", 32'(n), 32'd8);

    // Hold with step timer at 2: no pulses, then pulse 2 cycles after release.
    press(8'h20);
    tick();
    check("t4_moving", {31'd0, moving}, 32'd1);
    tick();
    tick();
    P = 1'b1;
    run_cycles(10, ups, downs);
    check("t4_hold_pulses", 32'(ups + downs), 32'd0);
    check("t4_hold_moving", {31'd0, moving}, 32'd1);
    check("t4_hold_floor", {29'd0, cur_floor}, 32'd2);
    P = 1'b0;
    wait_pulse(1'b1, 20, t);
    check("t4_resume", 32'(t), 32'd2);
    check("t4_floor3", {29'd0, cur_floor}, 32'd3);
    wait_pulse(1'b1, 20, t);
    wait_pulse(1'b1, 20, t);
    check("t4_floor5", {29'd0, cur_floor}, 32'd5);
    door_time(n);

    // Reset while moving down at floor 4.
    press(8'h01);
    wait_pulse(1'b0, 20, t);
    check("t6_floor4", {29'd0, cur_floor}, 32'd4);
    check("t6_moving", {31'd0, moving}, 32'd1);
    tick();
    reset = 1'b0;
    #1;
    check("t6_rst_floor", {29'd0, cur_floor}, 32'd0);
    check("t6_rst_dir", {31'd0, dir_up}, 32'd1);
    check("t6_rst_state", {30'd0, moving, door_open}, 32'd0);
    check("t6_rst_pend", {24'd0, pending}, 32'd0);
    check("t6_rst_outs", {30'd0, up, down}, 32'd3);
    tick();
    tick();
    reset = 1'b1;
    run_cycles(20, ups, downs);
    check("t6_quiet", 32'(ups + downs), 32'd0);
    check("t6_still_idle", {30'd0, moving, door_open}, 32'd0);

    // Full travel 0 -> 7, nothing beyond the top, then boundary reversal.
    press(8'h80);
    for (int i = 0; i < 7; i++) wait_pulse(1'b1, 20, t);
    check("t5_floor7", {29'd0, cur_floor}, 32'd7);
    check("t5_door", {31'd0, door_open}, 32'd1);
    door_time(n);
    run_cycles(10, ups, downs);
    check("t5_no_overrun", 32'(ups + downs), 32'd0);
    check("t5_floor7_idle", {29'd0, cur_floor}, 32'd7);
    press(8'h20);
    wait_pulse(1'b0, 20, t);
    wait_pulse(1'b0, 20, t);
    check("t5_floor5", {29'd0, cur_floor}, 32'd5);
    check("t5_dir_down", {31'd0, dir_up}, 32'd0);
    check("t5_wrong_pulses", 32'(wrong_pulses), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/elevator_motion_ctrl.md
Name: elevator_motion_ctrl

Overview:
- Command source for the floor up/down counter. Drives its active-low up/down step inputs and honours its P hold input.
- Latches active-low floor-call buttons and tracks the cabin floor in an internal mirror that advances with every step pulse it issues.
- Serves calls with a SCAN (keep direction while calls remain ahead) policy, then opens the door for a fixed time at each served floor.

Parameters:
- FLOORS, 8, number of floors; the top floor is FLOORS-1.
- FLOOR_W, 3, floor index width; must satisfy 2**FLOOR_W >= FLOORS.
- STEP_CYCLES, 4, clock cycles of travel per floor before a step pulse is issued.
- DOOR_CYCLES, 8, clock cycles the door stays open.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- call_n  in  FLOORS  floor-call buttons, active-low, level-sampled each clk.
- P  in  1  hold/obstruction, active-high; freezes all timers and suppresses steps.
- up  out  1  active-low one-cycle step-up pulse to the counter.
- down  out  1  active-low one-cycle step-down pulse to the counter.
- cur_floor  out  FLOOR_W  internal floor mirror.
- dir_up  out  1  current or last travel direction (1 = up).
- moving  out  1  high in state MOVE.
- door_open  out  1  high in state DOOR.
- pending  out  FLOORS  latched call register.

Behaviour:
- Reset values: up=1, down=1, cur_floor=0, dir_up=1, moving=0, door_open=0, pending=0, state=IDLE, both timers=0.
- Call latching:
  - Any call_n[i]==0 sets pending[i] on the next edge; bits are sticky.
  - pending[cur_floor] is cleared on entry to DOOR.
  - A call at cur_floor while in DOOR restarts the door timer and leaves the bit clear.
- States: IDLE, MOVE, DOOR.
- IDLE:
  - If pending[cur_floor]: go to DOOR.
  - Else if any call is ahead in dir_up: go to MOVE.
  - Else if any call is behind: toggle dir_up, go to MOVE.
  - Else stay in IDLE.
- MOVE:
  - step_timer counts 0..STEP_CYCLES-1. At terminal count, drive up=0 (dir_up=1) or down=0 (dir_up=0) for exactly one cycle, update cur_floor by ±1 in the same edge, and reload the timer to 0.
  - After a step: if pending[new floor], go to DOOR. Else if calls remain ahead, stay in MOVE. Else if calls are behind, toggle dir_up and stay in MOVE. Else go to IDLE.
- DOOR:
  - door_timer counts to DOOR_CYCLES-1, then the FSM goes to IDLE. Exit decisions are made only in IDLE; minimum IDLE dwell is 1 cycle.
- Boundaries:
  - No up pulse is issued at cur_floor==FLOORS-1 and no down pulse at 0. A SCAN decision that would cross a boundary toggles direction instead.
  - up and down are never low in the same cycle.
  - Latency from a call (cabin idle, call on a different floor) to the first step pulse: 1 latch cycle + 1 IDLE decision cycle + STEP_CYCLES.
- P=1:
  - All timers hold and no step pulse is emitted.
  - The FSM stays in its current state, including DOOR, so the door stays open.
  - call_n is still latched.
  - Timers resume from their held value when P returns to 0.
- Reset mid-operation: all state returns to reset values immediately. cur_floor=0 by contract; the counter is reset by the same reset net.
- Width rules: timers are sized to clog2 of their maximum count. cur_floor arithmetic never wraps.

Optional Feature:
- Macro: DOOR_HOLD_EN.
- With the macro defined:
  - Extra input door_hold_n (active-low).
  - While the FSM is in DOOR and door_hold_n==0, door_timer is held at 0.
  - Release resumes the full DOOR_CYCLES count.
- Without the macro: the port is absent and the door closes strictly after DOOR_CYCLES cycles (P excepted).

Decomposition:
- Shared package elevator_pkg holds:
  - state enum {IDLE, MOVE, DOOR};
  - default FLOORS, FLOOR_W, STEP_CYCLES, DOOR_CYCLES constants;
  - the active-low level constant used by up, down and call_n.
- One natural sub-module: call_scheduler, combinational. Inputs pending, cur_floor, dir_up; outputs here, ahead, behind.
- Timers and the FSM stay in the top module.

Test Plan:
- Reset, then call_n[3]=0 for 1 cycle: exactly 3 up pulses, each STEP_CYCLES=4 cycles apart. cur_floor=3, door_open=1 for 8 cycles, pending=0, then IDLE.
- Cabin at 3, idle; calls at 1 and 6 in the same cycle: SCAN serves 6 first (3 up pulses, door), then 1 (5 down pulses, door). dir_up toggles once.
- Cabin at 2, door open; call_n[2]=0 at door cycle 5: door_timer restarts and the door stays open 8 more cycles. pending[2] stays 0.
- In MOVE at step_timer=2, P=1 for 10 cycles: no pulses during hold. First pulse occurs 2 cycles after P falls (timer resumes 2→3 plus pulse edge).
- Call at 7 from floor 0 (FLOORS=8): exactly 7 up pulses, none beyond floor 7. up and down are never simultaneously 0 (assertion throughout).
- Reset asserted mid-MOVE at floor 4: all outputs return to reset values the same cycle, and no pulse follows until a new call.
